qmux_switch_ctrl: RTL and testbench

- Sequencing controller for one quadrant clock mux select (IS). Moves the mux between GMUXIN (IS=0) and QHSCK (IS=1) without glitches.
- Each switch runs as a fixed sequence: gate the downstream clock, flip IS, wait for the mux to settle, ungate.
- Requesters use a REQ/ACK handshake.
- A failsafe returns the mux to GMUXIN when the QHSCK source reports invalid.

---
 rtl/qmux_switch_ctrl_if.sv | 28 ++
 rtl/qmux_switch_ctrl.sv | 142 ++++++++++++++
 tb/tb_qmux_switch_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qmux_switch_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | qmux_switch_ctrl_if : request/status bundle of the QMUX switch control |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface qmux_switch_ctrl_if;
  logic REQ;
  logic REQ_SEL;
  logic HSCK_VALID;
  logic ERR_CLR;
  logic IS;
  logic GATE_EN;
  logic BUSY;
  logic ACK;
  logic NACK;
  logic ERR;

  modport master (
    output REQ, REQ_SEL, HSCK_VALID, ERR_CLR,
    input  IS, GATE_EN, BUSY, ACK, NACK, ERR
  );

  modport slave (
    input  REQ, REQ_SEL, HSCK_VALID, ERR_CLR,
    output IS, GATE_EN, BUSY, ACK, NACK, ERR
  );
endinterface
`default_nettype wire

// File: rtl/qmux_switch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | qmux_switch_ctrl : glitch-free gate/flip/settle sequencer for QMUX IS |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module qmux_switch_ctrl #(
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  wire logic         CLK,
  input  wire logic         RSTN,
  qmux_switch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, vld_q;
  logic             is_q, is_d;
  logic             tgt_q, tgt_d;
  logic             fs_q, fs_d;
  logic             gate_en_q, gate_en_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             nack_q, nack_d;
  logic             err_q, err_d;
  logic             err_set;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sync1_q   <= 1'b0;
      vld_q     <= 1'b0;
      is_q      <= 1'b0;
      tgt_q     <= 1'b0;
      fs_q      <= 1'b0;
      gate_en_q <= 1'b1;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      nack_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= bus.HSCK_VALID;
      vld_q     <= sync1_q;
      is_q      <= is_d;
      tgt_q     <= tgt_d;
      fs_q      <= fs_d;
      gate_en_q <= gate_en_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_d      = is_q;
    tgt_d     = tgt_q;
    fs_d      = fs_q;
    gate_en_d = gate_en_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    nack_d    = 1'b0;
    err_set   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Failsafe outranks any pending request on the same edge.
        if (is_q && !vld_q) begin
          state_d   = ST_GATE;
          cnt_d     = GATE_LOAD;
          gate_en_d = 1'b0;
          busy_d    = 1'b1;
          tgt_d     = 1'b0;
          fs_d      = 1'b1;
          err_set   = 1'b1;
        end else if (bus.REQ) begin
          if (bus.REQ_SEL && !vld_q) begin
            nack_d  = 1'b1;
            err_set = 1'b1;
          end else if (bus.REQ_SEL == is_q) begin
            ack_d = 1'b1;
          end else begin
            state_d   = ST_GATE;
            cnt_d     = GATE_LOAD;
            gate_en_d = 1'b0;
            busy_d    = 1'b1;
            tgt_d     = bus.REQ_SEL;
            fs_d      = 1'b0;
          end
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) begin
          is_d    = tgt_q;
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          gate_en_d = 1'b1;
          busy_d    = 1'b0;
          ack_d     = !fs_q;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    err_d = err_set | (err_q & ~bus.ERR_CLR);
  end

  assign bus.IS      = is_q;
  assign bus.GATE_EN = gate_en_q;
  assign bus.BUSY    = busy_q;
  assign bus.ACK     = ack_q;
  assign bus.NACK    = nack_q;
  assign bus.ERR     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_qmux_switch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_qmux_switch_ctrl : vector table, directed and randomized checks    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_qmux_switch_ctrl;
  localparam int G = 4;
  localparam int S = 4;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  qmux_switch_ctrl_if if1 ();
  qmux_switch_ctrl_if if2 ();

  qmux_switch_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8)) dut1 (
    .CLK(CLK), .RSTN(RSTN), .bus(if1.slave));
  qmux_switch_ctrl #(.GATE_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(8)) dut2 (
    .CLK(CLK), .RSTN(RSTN), .bus(if2.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: switches tracked by elapsed cycles since acceptance.
  logic m_h1, m_h2, m_is, m_busy, m_done, m_tgt, m_fs, m_ge, m_ack, m_nack, m_err;
  int   m_cyc, m_start;

  typedef struct {
    logic req, sel, hv, clr;
    logic ack, nack, err, is_o, busy, ge;
  } vec_t;
  vec_t tbl[20];

  function automatic vec_t mk(input logic [3:0] in, input logic [5:0] ex);
    vec_t v;
    {v.req, v.sel, v.hv, v.clr} = in;
    {v.ack, v.nack, v.err, v.is_o, v.busy, v.ge} = ex;
    return v;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h1 = 0; m_h2 = 0; m_is = 0; m_busy = 0; m_done = 0; m_tgt = 0; m_fs = 0;
    m_ge = 1; m_ack = 0; m_nack = 0; m_err = 0; m_cyc = 0; m_start = 0;
  endtask

  task automatic model_edge(input logic r, input logic s, input logic h, input logic c);
    logic vld, eset;
    int   el;
    vld = m_h2; m_h2 = m_h1; m_h1 = h;
    m_ack = 0; m_nack = 0; eset = 0;
    if (m_busy) begin
      el = m_cyc - m_start;
      if (el == G) m_is = m_tgt;
      if (el == G + S) begin
        m_ge = 1; m_busy = 0; m_done = 1; m_ack = !m_fs;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (m_is && !vld) begin
      m_busy = 1; m_ge = 0; m_start = m_cyc; m_tgt = 0; m_fs = 1; eset = 1;
    end else if (r) begin
      if (s && !vld) begin
        m_nack = 1; eset = 1;
      end else if (s == m_is) begin
        m_ack = 1;
      end else begin
        m_busy = 1; m_ge = 0; m_start = m_cyc; m_tgt = s; m_fs = 0;
      end
    end
    m_err = eset | (m_err & !c);
    m_cyc++;
  endtask

  task automatic cmp_model();
    chk("IS",      if1.IS,      m_is);
    chk("GATE_EN", if1.GATE_EN, m_ge);
    chk("BUSY",    if1.BUSY,    m_busy);
    chk("ACK",     if1.ACK,     m_ack);
    chk("NACK",    if1.NACK,    m_nack);
    chk("ERR",     if1.ERR,     m_err);
  endtask

  task automatic cyc1(input logic r, input logic s, input logic h, input logic c);
    if1.REQ = r; if1.REQ_SEL = s; if1.HSCK_VALID = h; if1.ERR_CLR = c;
    @(posedge CLK);
    model_edge(r, s, h, c);
    #1;
    cmp_model();
  endtask

  task automatic cyc2(input logic r, input logic s, input logic h);
    if2.REQ = r; if2.REQ_SEL = s; if2.HSCK_VALID = h; if2.ERR_CLR = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic r_req, r_sel, r_hv, r_clr;
    int   lowcnt, ackcnt, nackcnt, first_is;
    bit   ok;

    if1.REQ = 0; if1.REQ_SEL = 0; if1.HSCK_VALID = 0; if1.ERR_CLR = 0;
    if2.REQ = 0; if2.REQ_SEL = 0; if2.HSCK_VALID = 0; if2.ERR_CLR = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_IS", if1.IS, 1'b0);     chk("rst_GATE_EN", if1.GATE_EN, 1'b1);
    chk("rst_BUSY", if1.BUSY, 1'b0); chk("rst_ACK", if1.ACK, 1'b0);
    chk("rst_NACK", if1.NACK, 1'b0); chk("rst_ERR", if1.ERR, 1'b0);
    RSTN = 1'b1;

    // reject, ERR_CLR, no-op, set-wins, then a full 0->1 switch
    tbl[0]  = mk(4'b1100, 6'b011001);
    tbl[1]  = mk(4'b0000, 6'b001001);
    tbl[2]  = mk(4'b0001, 6'b000001);
    tbl[3]  = mk(4'b1000, 6'b100001);
    tbl[4]  = mk(4'b0000, 6'b000001);
    tbl[5]  = mk(4'b1101, 6'b011001);
    tbl[6]  = mk(4'b0000, 6'b001001);
    tbl[7]  = mk(4'b0001, 6'b000001);
    tbl[8]  = mk(4'b0010, 6'b000001);
    tbl[9]  = mk(4'b0010, 6'b000001);
    for (int i = 10; i < 14; i++) tbl[i] = mk(4'b1110, 6'b000010);
    for (int i = 14; i < 18; i++) tbl[i] = mk(4'b1110, 6'b000110);
    tbl[18] = mk(4'b1110, 6'b100101);
    tbl[19] = mk(4'b0010, 6'b000101);
    for (int i = 0; i < 20; i++) begin
      if1.REQ = tbl[i].req; if1.REQ_SEL = tbl[i].sel;
      if1.HSCK_VALID = tbl[i].hv; if1.ERR_CLR = tbl[i].clr;
      @(posedge CLK);
      model_edge(tbl[i].req, tbl[i].sel, tbl[i].hv, tbl[i].clr);
      #1;
      chk($sformatf("tbl%0d_ACK", i),  if1.ACK,     tbl[i].ack);
      chk($sformatf("tbl%0d_NACK", i), if1.NACK,    tbl[i].nack);
      chk($sformatf("tbl%0d_ERR", i),  if1.ERR,     tbl[i].err);
      chk($sformatf("tbl%0d_IS", i),   if1.IS,      tbl[i].is_o);
      chk($sformatf("tbl%0d_BUSY", i), if1.BUSY,    tbl[i].busy);
      chk($sformatf("tbl%0d_GE", i),   if1.GATE_EN, tbl[i].ge);
    end

    // switch back to GMUXIN: IS falls after E4, gate low exactly G+S cycles
    lowcnt = 0; ackcnt = 0; first_is = -1;
    for (int k = 0; k < 12; k++) begin
      cyc1(k <= 8, 1'b0, 1'b1, 1'b0);
      if (!if1.GATE_EN) lowcnt++;
      if (if1.ACK) ackcnt++;
      if (first_is < 0 && !if1.IS) first_is = k;
    end
    chk("back_gate_low_8", lowcnt == G + S, 1'b1);
    chk("back_is_at_E4", first_is == G, 1'b1);
    chk("back_one_ack", ackcnt == 1, 1'b1);

    // failsafe: go to QHSCK, drop HSCK_VALID, request on the failsafe edge
    for (int k = 0; k < 11; k++) cyc1(k <= 8, 1'b1, 1'b1, 1'b0);
    chk("fs_pre_IS", if1.IS, 1'b1);
    cyc1(1'b0, 1'b1, 1'b0, 1'b0);
    cyc1(1'b0, 1'b1, 1'b0, 1'b0);
    ackcnt = 0; nackcnt = 0; ok = 0;
    cyc1(1'b1, 1'b1, 1'b0, 1'b0);
    chk("fs_start_BUSY", if1.BUSY, 1'b1);
    chk("fs_start_ERR", if1.ERR, 1'b1);
    for (int k = 0; k < 20 && !ok; k++) begin
      cyc1(1'b1, 1'b1, 1'b0, 1'b0);
      if (if1.ACK) ackcnt++;
      if (if1.NACK) begin nackcnt++; ok = 1; end
    end
    chk("fs_nack_timeout", ok, 1'b1);
    chk("fs_no_ack", ackcnt == 0, 1'b1);
    chk("fs_end_IS", if1.IS, 1'b0);
    cyc1(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fs_errclr", if1.ERR, 1'b0);

    // randomized requesters against the model
    r_req = 0; r_sel = 0; r_hv = 1; r_clr = 0;
    for (int k = 0; k < 3000; k++) begin
      if (r_req && (if1.ACK || if1.NACK)) r_req = 0;
      else if (!r_req && $urandom_range(0, 3) == 0) begin
        r_req = 1; r_sel = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) r_hv = !r_hv;
      r_clr = ($urandom_range(0, 9) == 0);
      cyc1(r_req, r_sel, r_hv, r_clr);
    end

    // asynchronous reset in the middle of GATE
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      cyc1(1'b0, 1'b0, 1'b1, 1'b0);
      if (k >= 3 && !m_busy && !m_done) ok = 1;
    end
    chk("drain_timeout", ok, 1'b1);
    r_sel = !m_is;
    for (int k = 0; k < 3; k++) cyc1(1'b1, r_sel, 1'b1, 1'b0);
    chk("arst_pre_BUSY", if1.BUSY, 1'b1);
    #3 RSTN = 1'b0;
    #1;
    chk("arst_IS", if1.IS, 1'b0);     chk("arst_GATE_EN", if1.GATE_EN, 1'b1);
    chk("arst_BUSY", if1.BUSY, 1'b0); chk("arst_ACK", if1.ACK, 1'b0);
    chk("arst_NACK", if1.NACK, 1'b0); chk("arst_ERR", if1.ERR, 1'b0);
    if1.REQ = 0; if1.HSCK_VALID = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    ackcnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc1(1'b0, 1'b0, 1'b0, 1'b0);
      if (if1.ACK) ackcnt++;
    end
    chk("arst_no_ack", ackcnt == 0, 1'b1);

    // minimal timing instance: GATE_CYCLES=1, SETTLE_CYCLES=1
    lowcnt = 0;
    for (int k = 0; k < 3; k++) cyc2(1'b0, 1'b0, 1'b1);
    cyc2(1'b1, 1'b1, 1'b1);
    chk("g1_E0_GE", if2.GATE_EN, 1'b0); chk("g1_E0_IS", if2.IS, 1'b0);
    chk("g1_E0_BUSY", if2.BUSY, 1'b1);
    if (!if2.GATE_EN) lowcnt++;
    cyc2(1'b1, 1'b1, 1'b1);
    chk("g1_E1_IS", if2.IS, 1'b1); chk("g1_E1_GE", if2.GATE_EN, 1'b0);
    chk("g1_E1_ACK", if2.ACK, 1'b0);
    if (!if2.GATE_EN) lowcnt++;
    cyc2(1'b1, 1'b1, 1'b1);
    chk("g1_E2_ACK", if2.ACK, 1'b1); chk("g1_E2_GE", if2.GATE_EN, 1'b1);
    chk("g1_E2_BUSY", if2.BUSY, 1'b0);
    cyc2(1'b0, 1'b1, 1'b1);
    chk("g1_E3_ACK", if2.ACK, 1'b0);
    chk("g1_gate_low_2", lowcnt == 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
